// File: rtl/seven_seg_game_ctrl.sv
// "Stop the digits" game controller: NUM_DIGITS digits share one free-running value,
// button presses freeze them in order. Optional segment decoder: SEVEN_SEG_GAME_DECODE_EN.
module seven_seg_game_ctrl #(
   parameter int NUM_DIGITS     = 6,
   parameter int DIGIT_MAX      = 9,
   parameter int TIMER_W        = 32,
   parameter int TIMER_DEFAULT  = 10000000,
   parameter int TIMER_DECREASE = 1000000,
   parameter int TIMER_MIN      = 1000000
) (
   input  logic                    iClk,
   input  logic                    iRst_n,
   input  logic                    iBtn,
   input  logic                    iClear,
   output logic [4*NUM_DIGITS-1:0] oDigits,
   output logic [NUM_DIGITS-1:0]   oHex_en,
   output logic                    oAllDisabled,
   output logic                    oMatch,
   output logic [3:0]              oLevel,
   output logic [1:0]              oState
`ifdef SEVEN_SEG_GAME_DECODE_EN
   ,
   output logic [7*NUM_DIGITS-1:0] oHex
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [TIMER_W-1:0]    PERIOD_DEF = TIMER_W'(TIMER_DEFAULT);
   localparam logic [TIMER_W-1:0]    PERIOD_DEC = TIMER_W'(TIMER_DECREASE);
   localparam logic [TIMER_W-1:0]    PERIOD_MIN = TIMER_W'(TIMER_MIN);
   localparam logic [3:0]            VALUE_MAX  = 4'(DIGIT_MAX);
   localparam logic [NUM_DIGITS-1:0] ALL_ON     = '1;

   state_t                  state_reg;
   logic [TIMER_W-1:0]      timer_reg;
   logic [TIMER_W-1:0]      period_reg;
   logic [3:0]              value_reg;
   logic [3:0]              level_reg;
   logic [NUM_DIGITS-1:0]   hex_en_reg;
   logic [3:0]              cap_reg  [NUM_DIGITS];
   logic [3:0]              cap_next [NUM_DIGITS];
   logic                    all_dis_reg;
   logic                    match_reg;

   logic                    tick;
   logic                    btn_run;
   logic                    last_press;
   logic                    match_next;
   logic [NUM_DIGITS-1:0]   lowest_en;
   logic [TIMER_W:0]        floor_plus_dec;
   logic [TIMER_W-1:0]      period_dn;

   assign tick      = (timer_reg == period_reg - TIMER_W'(1));
   assign btn_run   = iBtn && !iClear && (state_reg == ST_RUN);
   // Isolate the lowest still-running digit; that is the one a press freezes.
   assign lowest_en  = hex_en_reg & (~hex_en_reg + NUM_DIGITS'(1));
   assign last_press = btn_run && (hex_en_reg == lowest_en);

   // Compare in TIMER_W+1 bits so the floor test can never wrap.
   assign floor_plus_dec = {1'b0, PERIOD_MIN} + {1'b0, PERIOD_DEC};
   assign period_dn      = ({1'b0, period_reg} >= floor_plus_dec) ? (period_reg - PERIOD_DEC)
                                                                 : PERIOD_MIN;

   always_comb begin
      match_next = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (cap_next[k] != cap_next[0]) match_next = 1'b0;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_reg   <= ST_IDLE;
         timer_reg   <= '0;
         value_reg   <= '0;
         period_reg  <= PERIOD_DEF;
         level_reg   <= '0;
         hex_en_reg  <= ALL_ON;
         all_dis_reg <= 1'b0;
         match_reg   <= 1'b0;
      end else if (iClear) begin
         state_reg   <= ST_IDLE;
         timer_reg   <= '0;
         value_reg   <= '0;
         period_reg  <= PERIOD_DEF;
         level_reg   <= '0;
         hex_en_reg  <= ALL_ON;
         all_dis_reg <= 1'b0;
         match_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (iBtn) state_reg <= ST_RUN;
            end
            ST_RUN: begin
               timer_reg <= tick ? '0 : timer_reg + TIMER_W'(1);
               if (tick) value_reg <= (value_reg == VALUE_MAX) ? 4'd0 : value_reg + 4'd1;
               if (iBtn) begin
                  hex_en_reg <= hex_en_reg & ~lowest_en;
                  if (last_press) begin
                     state_reg   <= ST_DONE;
                     all_dis_reg <= 1'b1;
                     match_reg   <= match_next;
                  end
               end
            end
            ST_DONE: begin
               // Speed changes only here, so a count is never cut short.
               if (iBtn) begin
                  period_reg  <= period_dn;
                  level_reg   <= (level_reg == 4'd15) ? 4'd15 : level_reg + 4'd1;
                  timer_reg   <= '0;
                  hex_en_reg  <= ALL_ON;
                  state_reg   <= ST_RUN;
                  all_dis_reg <= 1'b0;
                  match_reg   <= 1'b0;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign cap_next[gi] = (btn_run && lowest_en[gi]) ? value_reg : cap_reg[gi];

         always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n)     cap_reg[gi] <= '0;
            else if (iClear) cap_reg[gi] <= '0;
            else             cap_reg[gi] <= cap_next[gi];
         end

         assign oDigits[4*gi +: 4] = hex_en_reg[gi] ? value_reg : cap_reg[gi];
      end
   endgenerate

   assign oHex_en      = hex_en_reg;
   assign oAllDisabled = all_dis_reg;
   assign oMatch       = match_reg;
   assign oLevel       = level_reg;
   assign oState       = state_reg;

`ifdef SEVEN_SEG_GAME_DECODE_EN
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_decode
         always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) oHex[7*gi +: 7] <= 7'b1000000;
            else         oHex[7*gi +: 7] <= seg7(oDigits[4*gi +: 4]);
         end
      end
   endgenerate
`endif

endmodule
